sg_desc_fetch: RTL and testbench

Wishbone master engine that reads a 4-word scatter-gather descriptor from system memory and writes back its state byte. It is the initiator counterpart of the DMA register slave: software loads the descriptor address through the register file, and the DMA controller then uses this block to fetch descriptors. It also uses it to post completion state back to memory. Fetched fields are presented as a coherent set in the sg_next/sg_addr/sg_desc/sg_state format the controller already consumes.

---
 rtl/sg_desc_fetch_pkg.sv | 23 ++
 rtl/sg_desc_fetch_beat_timer.sv | 54 +++++
 rtl/sg_desc_fetch.sv | 179 +++++++++++++++++
 tb/tb_sg_desc_fetch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sg_desc_fetch_pkg.sv
// rtl/sg_desc_fetch_pkg.sv - shared state encoding, descriptor layout and address helper for sg_desc_fetch
package sg_desc_fetch_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_WR      = 3'd2;
  localparam logic [2:0] ST_RTY_GAP = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;

  localparam logic [1:0] WORD_NEXT  = 2'd0;
  localparam logic [1:0] WORD_ADDR  = 2'd1;
  localparam logic [1:0] WORD_DESC  = 2'd2;
  localparam logic [1:0] WORD_STATE = 2'd3;

  localparam logic [3:0] SEL_STATE = 4'b0001;
  localparam logic [3:0] SEL_WORD  = 4'b1111;

  function automatic logic [31:0] word_adr(input logic [28:0] base, input logic [1:0] word);
    return {base, 3'b000} + {28'h0, word, 2'b00};
  endfunction

endpackage

// File: rtl/sg_desc_fetch_beat_timer.sv
// rtl/sg_desc_fetch_beat_timer.sv - sg_beat_timer: per-beat response timeout and optional retry budget (SG_FETCH_RTY_EN)
module sg_beat_timer #(
  parameter int RETRY_MAX = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clear,
  input  logic tick,
  input  logic rsp_ack,
  input  logic rsp_err,
  input  logic rsp_rty,
  output logic timeout,
  output logic retry_exhausted
);

  logic [7:0] tcnt;
  logic       any_rsp;

  assign any_rsp = rsp_ack | rsp_err | rsp_rty;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      tcnt <= 8'd0;
    else if (clear || any_rsp || !tick)
      tcnt <= 8'd0;
    else
      tcnt <= tcnt + 8'd1;
  end

  // Fires on the TIMEOUT-th consecutive silent strobe cycle of a beat.
  assign timeout = tick && !any_rsp && (tcnt == 8'(TIMEOUT - 1));

`ifdef SG_FETCH_RTY_EN
  localparam int RW = $clog2(RETRY_MAX + 1);

  logic [RW-1:0] rcnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      rcnt <= '0;
    else if (clear || rsp_ack)
      rcnt <= '0;
    else if (rsp_rty)
      rcnt <= rcnt + RW'(1);
  end

  assign retry_exhausted = rsp_rty && (rcnt == RW'(RETRY_MAX));
`else
  localparam int unused_retry_max = RETRY_MAX;
  assign retry_exhausted = 1'b0;
`endif

endmodule

// File: rtl/sg_desc_fetch.sv
// rtl/sg_desc_fetch.sv - Wishbone master that fetches a 4-word SG descriptor and writes back its state byte
// Optional rty retry handling is built when SG_FETCH_RTY_EN is defined.
module sg_desc_fetch
  import sg_desc_fetch_pkg::*;
#(
  parameter int RETRY_MAX = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        fetch_req,
  input  logic        wr_req,
  input  logic [28:0] desc_adr,
  input  logic [7:0]  wr_state,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [28:0] sg_next,
  output logic [28:0] sg_addr,
  output logic [15:0] sg_desc,
  output logic [7:0]  sg_state,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_cab_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);

  logic [2:0]  state;
  logic [1:0]  beat;
  logic [28:0] adr_q;
  logic [7:0]  wr_byte;
  logic [28:0] sh_next;
  logic [28:0] sh_addr;
  logic [15:0] sh_desc;
  logic        stb_phase;
  logic        timeout;
  logic        retry_exhausted;
`ifdef SG_FETCH_RTY_EN
  logic        is_wr;
`endif

  assign stb_phase = (state == ST_RD) || (state == ST_WR);

  sg_beat_timer #(
    .RETRY_MAX (RETRY_MAX),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_i        (wb_rst_i),
    .clear           (state == ST_IDLE),
    .tick            (stb_phase),
    .rsp_ack         (stb_phase & wbm_ack_i),
    .rsp_err         (stb_phase & wbm_err_i),
    .rsp_rty         (stb_phase & wbm_rty_i),
    .timeout         (timeout),
    .retry_exhausted (retry_exhausted)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      beat     <= 2'd0;
      adr_q    <= '0;
      wr_byte  <= '0;
      sh_next  <= '0;
      sh_addr  <= '0;
      sh_desc  <= '0;
      sg_next  <= '0;
      sg_addr  <= '0;
      sg_desc  <= '0;
      sg_state <= '0;
`ifdef SG_FETCH_RTY_EN
      is_wr    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          beat <= 2'd0;
          if (fetch_req) begin
            adr_q <= desc_adr;
            state <= ST_RD;
`ifdef SG_FETCH_RTY_EN
            is_wr <= 1'b0;
`endif
          end else if (wr_req) begin
            adr_q   <= desc_adr;
            wr_byte <= wr_state;
            state   <= ST_WR;
`ifdef SG_FETCH_RTY_EN
            is_wr   <= 1'b1;
`endif
          end
        end
        ST_RD, ST_WR: begin
          if (wbm_err_i || timeout) begin
            state <= ST_ERR;
          end else if (wbm_rty_i) begin
`ifdef SG_FETCH_RTY_EN
            state <= retry_exhausted ? ST_ERR : ST_RTY_GAP;
`else
            state <= ST_ERR;
`endif
          end else if (wbm_ack_i) begin
            if (state == ST_WR) begin
              state <= ST_DONE;
            end else begin
              beat <= beat + 2'd1;
              case (beat)
                WORD_NEXT: sh_next <= wbm_dat_i[31:3];
                WORD_ADDR: sh_addr <= wbm_dat_i[31:3];
                WORD_DESC: sh_desc <= wbm_dat_i[15:0];
                default: begin
                  // Whole descriptor lands on the sg_* outputs in one edge.
                  sg_next  <= sh_next;
                  sg_addr  <= sh_addr;
                  sg_desc  <= sh_desc;
                  sg_state <= wbm_dat_i[7:0];
                  state    <= ST_DONE;
                end
              endcase
            end
          end
        end
`ifdef SG_FETCH_RTY_EN
        ST_RTY_GAP: state <= is_wr ? ST_WR : ST_RD;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign err  = (state == ST_ERR);

  always_comb begin
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;
    wbm_we_o  = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_cab_o = 1'b0;
    case (state)
      ST_RD: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_cab_o = 1'b1;
        wbm_sel_o = SEL_WORD;
        wbm_adr_o = word_adr(adr_q, beat);
      end
      ST_WR: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_sel_o = SEL_STATE;
        wbm_adr_o = word_adr(adr_q, WORD_STATE);
        wbm_dat_o = {24'h0, wr_byte};
      end
`ifdef SG_FETCH_RTY_EN
      ST_RTY_GAP: begin
        wbm_cyc_o = 1'b1;
        wbm_cab_o = ~is_wr;
        wbm_we_o  = is_wr;
        wbm_adr_o = word_adr(adr_q, is_wr ? WORD_STATE : beat);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sg_desc_fetch.sv
// tb/tb_sg_desc_fetch.sv - directed self-checking bench for sg_desc_fetch
module tb_sg_desc_fetch;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        fetch_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [28:0] desc_adr = 29'h0000_0200;
  logic [7:0]  wr_state = 8'h00;
  logic        busy, done, err;
  logic [28:0] sg_next, sg_addr;
  logic [15:0] sg_desc;
  logic [7:0]  sg_state;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cab_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

  sg_desc_fetch dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .fetch_req (fetch_req), .wr_req (wr_req),
    .desc_adr (desc_adr), .wr_state (wr_state),
    .busy (busy), .done (done), .err (err),
    .sg_next (sg_next), .sg_addr (sg_addr), .sg_desc (sg_desc), .sg_state (sg_state),
    .wbm_adr_o (wbm_adr_o), .wbm_dat_o (wbm_dat_o), .wbm_dat_i (wbm_dat_i),
    .wbm_sel_o (wbm_sel_o), .wbm_we_o (wbm_we_o), .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o), .wbm_cab_o (wbm_cab_o),
    .wbm_ack_i (wbm_ack_i), .wbm_err_i (wbm_err_i), .wbm_rty_i (wbm_rty_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Zero-wait slave with programmable error / retry / silence injection.
  logic [31:0] mem [4];
  logic        silent = 1'b0;
  logic        err_en = 1'b0;
  logic [1:0]  err_beat = 2'd0;
  logic [1:0]  rty_beat = 2'd0;
  int          rty_limit = 0;
  int          rty_base = 0;
  int          rty_seen = 0;
  logic        req_phase, err_hit, rty_hit;

  assign req_phase = wbm_cyc_o && wbm_stb_o && !silent;
  assign err_hit   = err_en && !wbm_we_o && (wbm_adr_o[3:2] == err_beat);
  assign rty_hit   = !wbm_we_o && (wbm_adr_o[3:2] == rty_beat) && ((rty_seen - rty_base) < rty_limit);
  assign wbm_err_i = req_phase && err_hit;
  assign wbm_rty_i = req_phase && !err_hit && rty_hit;
  assign wbm_ack_i = req_phase && !err_hit && !rty_hit;
  assign wbm_dat_i = mem[wbm_adr_o[3:2]];

  int          log_n = 0;
  int          gap_n = 0;
  logic [31:0] log_adr [1024];
  logic [31:0] log_dat [1024];
  logic [3:0]  log_sel [1024];
  logic        log_we  [1024];

  always @(posedge wb_clk_i) begin
    if (wbm_rty_i) rty_seen <= rty_seen + 1;
    if (wbm_cyc_o && !wbm_stb_o) gap_n <= gap_n + 1;
    if (wbm_ack_i && log_n < 1024) begin
      log_adr[log_n] <= wbm_adr_o;
      log_dat[log_n] <= wbm_dat_o;
      log_sel[log_n] <= wbm_sel_o;
      log_we[log_n]  <= wbm_we_o;
      log_n <= log_n + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int   k, lb, gb;
  logic d, e, busy1, cyc_end;

  task automatic run_req(input logic f, input logic w);
    lb = log_n;
    gb = gap_n;
    @(negedge wb_clk_i);
    fetch_req = f;
    wr_req = w;
    k = 0; d = 1'b0; e = 1'b0; busy1 = 1'b0; cyc_end = 1'b1;
    while (k < 400 && !d && !e) begin
      @(negedge wb_clk_i);
      k++;
      fetch_req = 1'b0;
      wr_req = 1'b0;
      if (k == 1) busy1 = busy;
      d = done;
      e = err;
      cyc_end = wbm_cyc_o;
    end
  endtask

  initial begin
    mem[0] = 32'h0000_2008;
    mem[1] = 32'h0000_3000;
    mem[2] = 32'h0000_ABCD;
    mem[3] = 32'h0000_0055;
    repeat (2) @(negedge wb_clk_i);
    chk("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, wbm_stb_o}, 32'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_flags", {29'h0, busy, done, err}, 32'h0);
    chk("rst_sg_next", {3'h0, sg_next}, 32'h0);
    chk("rst_sg_state", {24'h0, sg_state}, 32'h0);
    wb_rst_i = 1'b0;

    // Zero-wait 4-beat fetch.
    run_req(1'b1, 1'b0);
    chk("fetch_done", {31'h0, d}, 32'h1);
    chk("fetch_latency", k, 5);
    chk("fetch_busy_n1", {31'h0, busy1}, 32'h1);
    chk("fetch_beats", log_n - lb, 4);
    chk("fetch_adr0", log_adr[lb], 32'h1000);
    chk("fetch_adr1", log_adr[lb+1], 32'h1004);
    chk("fetch_adr2", log_adr[lb+2], 32'h1008);
    chk("fetch_adr3", log_adr[lb+3], 32'h100C);
    chk("fetch_we_sel", {27'h0, log_we[lb], log_sel[lb]}, 32'h0F);
    chk("fetch_sg_next", {3'h0, sg_next}, 32'h401);
    chk("fetch_sg_addr", {3'h0, sg_addr}, 32'h600);
    chk("fetch_sg_desc", {16'h0, sg_desc}, 32'hABCD);
    chk("fetch_sg_state", {24'h0, sg_state}, 32'h55);
    @(negedge wb_clk_i);
    chk("fetch_after", {29'h0, busy, done, wbm_cyc_o}, 32'h0);

    // State write-back.
    wr_state = 8'hA5;
    run_req(1'b0, 1'b1);
    chk("wr_done", {31'h0, d}, 32'h1);
    chk("wr_latency", k, 2);
    chk("wr_beats", log_n - lb, 1);
    chk("wr_adr", log_adr[lb], 32'h100C);
    chk("wr_we_sel", {27'h0, log_we[lb], log_sel[lb]}, 32'h11);
    chk("wr_dat", log_dat[lb], 32'h0000_00A5);
    chk("wr_sg_state", {24'h0, sg_state}, 32'h55);
    chk("wr_sg_next", {3'h0, sg_next}, 32'h401);

    // Bus error on beat 2 discards the partial fetch.
    mem[0] = 32'hFFFF_FFF8;
    mem[1] = 32'h1234_5678;
    err_en = 1'b1;
    err_beat = 2'd2;
    run_req(1'b1, 1'b0);
    err_en = 1'b0;
    chk("err_pulse", {30'h0, d, e}, 32'h1);
    chk("err_latency", k, 4);
    chk("err_cyc_low", {31'h0, cyc_end}, 32'h0);
    chk("err_sg_next", {3'h0, sg_next}, 32'h401);
    chk("err_sg_addr", {3'h0, sg_addr}, 32'h600);
    @(negedge wb_clk_i);
    chk("err_one_cycle", {30'h0, busy, err}, 32'h0);
    mem[0] = 32'h0000_2008;
    mem[1] = 32'h0000_3000;

    // Retry on beat 1.
    mem[3] = 32'h0000_0066;
    rty_beat = 2'd1;
    rty_base = rty_seen;
    rty_limit = 2;
    run_req(1'b1, 1'b0);
`ifdef SG_FETCH_RTY_EN
    chk("rty_done", {30'h0, d, e}, 32'h2);
    chk("rty_latency", k, 9);
    chk("rty_gaps", gap_n - gb, 2);
    chk("rty_adr1", log_adr[lb+1], 32'h1004);
    chk("rty_sg_state", {24'h0, sg_state}, 32'h66);
    rty_base = rty_seen;
    rty_limit = 5;
    run_req(1'b1, 1'b0);
    chk("rty_exhaust", {30'h0, d, e}, 32'h1);
    chk("rty_exhaust_lat", k, 11);
    chk("rty_exhaust_sg", {24'h0, sg_state}, 32'h66);
`else
    chk("rty_is_err", {30'h0, d, e}, 32'h1);
    chk("rty_err_latency", k, 3);
    chk("rty_sg_state", {24'h0, sg_state}, 32'h55);
`endif
    rty_limit = 0;

    // Silent slave runs into the timeout.
    silent = 1'b1;
    run_req(1'b1, 1'b0);
    silent = 1'b0;
    chk("tmo_err", {30'h0, d, e}, 32'h1);
    chk("tmo_latency", k, 256);

    // Simultaneous requests: the read wins.
    mem[2] = 32'h0000_1357;
    wr_state = 8'h3C;
    run_req(1'b1, 1'b1);
    chk("both_done", {30'h0, d, e}, 32'h2);
    chk("both_latency", k, 5);
    chk("both_beats", log_n - lb, 4);
    chk("both_we", {28'h0, log_we[lb], log_we[lb+1], log_we[lb+2], log_we[lb+3]}, 32'h0);
    chk("both_sg_desc", {16'h0, sg_desc}, 32'h1357);

    // Asynchronous reset during beat 2.
    @(negedge wb_clk_i);
    fetch_req = 1'b1;
    @(negedge wb_clk_i);
    fetch_req = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    chk("mid_beat2_adr", wbm_adr_o, 32'h1008);
    wb_rst_i = 1'b1;
    #1;
    chk("mid_rst_bus", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_sg", {3'h0, sg_next}, 32'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    mem[2] = 32'h0000_2468;
    run_req(1'b1, 1'b0);
    chk("post_rst_done", {30'h0, d, e}, 32'h2);
    chk("post_rst_latency", k, 5);
    chk("post_rst_sg_desc", {16'h0, sg_desc}, 32'h2468);
    chk("post_rst_sg_addr", {3'h0, sg_addr}, 32'h600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
